// File: rtl/jtcop_mcu_mbox_pkg.sv
// Shared definitions for the Dec0/Robocop CPU <-> i8751 mailbox.
// Contents:
//   state_t      mailbox FSM encoding
//   P2_*         bit positions inside MCU port 2
//   STB_*        positions of the port-2 strobes inside the sampled nibble p2o[7:4]
//   ST_*_BIT     bit positions of the CPU-visible status word
//   merge_be     byte-enable merge of a 16-bit write
//   status_word  assembles the CPU status word
package jtcop_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_BUSY = 2'd2,
    S_RDY  = 2'd3
  } state_t;

  localparam int P2_ACK  = 3;
  localparam int P2_RDHI = 4;
  localparam int P2_RDLO = 5;
  localparam int P2_WRLO = 6;
  localparam int P2_WRHI = 7;

  // The strobe sampler sees p2o[7:4], so these are P2_* minus 4.
  localparam int STB_RDHI = P2_RDHI - 4;
  localparam int STB_RDLO = P2_RDLO - 4;
  localparam int STB_WRLO = P2_WRLO - 4;
  localparam int STB_WRHI = P2_WRHI - 4;

  localparam int ST_BUSY_BIT = 0;
  localparam int ST_RSPV_BIT = 1;
  localparam int ST_OVR_BIT  = 2;
  localparam int ST_TMO_BIT  = 3;

  // dsn is active-low {UDS, LDS}; a disabled byte keeps its old value.
  function automatic logic [15:0] merge_be(input logic [15:0] old_w,
                                           input logic [15:0] new_w,
                                           input logic [1:0]  dsn);
    logic [15:0] res;
    res = old_w;
    if (!dsn[1]) res[15:8] = new_w[15:8];
    else         res[15:8] = old_w[15:8];
    if (!dsn[0]) res[7:0]  = new_w[7:0];
    else         res[7:0]  = old_w[7:0];
    return res;
  endfunction

  function automatic logic [15:0] status_word(input logic tmo, input logic ovr,
                                              input logic rspv, input logic busy);
    logic [15:0] res;
    res = 16'd0;
    res[ST_TMO_BIT]  = tmo;
    res[ST_OVR_BIT]  = ovr;
    res[ST_RSPV_BIT] = rspv;
    res[ST_BUSY_BIT] = busy;
    return res;
  endfunction

endpackage

// File: rtl/jtcop_mcu_mbox_if.sv
// Bus bundle between the mailbox and its two clients (68000 side, i8751 side).
// Signals:
//   cpu_cs/cpu_addr/cpu_rnw/cpu_dsn/cpu_dout  CPU access (one-cycle strobe)
//   cpu_din                                   registered read data to CPU
//   mcu_p0o/mcu_p2o                           MCU port outputs
//   mcu_p0i/mcu_intn/mcu_st                   mailbox drive back to the MCU
// Modports: master = the CPU/MCU side, slave = the mailbox.
interface jtcop_mcu_mbox_if;
  logic        cpu_cs;
  logic        cpu_addr;
  logic        cpu_rnw;
  logic [1:0]  cpu_dsn;
  logic [15:0] cpu_dout;
  logic [15:0] cpu_din;
  logic [7:0]  mcu_p0o;
  logic [7:0]  mcu_p2o;
  logic [7:0]  mcu_p0i;
  logic        mcu_intn;
  logic [2:0]  mcu_st;

  modport master (
    output cpu_cs, cpu_addr, cpu_rnw, cpu_dsn, cpu_dout, mcu_p0o, mcu_p2o,
    input  cpu_din, mcu_p0i, mcu_intn, mcu_st
  );

  modport slave (
    input  cpu_cs, cpu_addr, cpu_rnw, cpu_dsn, cpu_dout, mcu_p0o, mcu_p2o,
    output cpu_din, mcu_p0i, mcu_intn, mcu_st
  );
endinterface

// File: rtl/jtcop_mcu_mbox_edge.sv
// Sampler and falling-edge detector for the four port-2 strobes p2o[7:4].
// Ports:
//   clk, rstn   clock, asynchronous active-low reset
//   i_stb[3:0]  raw strobes (active-low)
//   o_lvl[3:0]  registered strobe levels
//   o_fall[3:0] one-cycle pulse when a sampled strobe goes high -> low
module jtcop_mcu_edge (
  input  logic       clk,
  input  logic       rstn,
  input  logic [3:0] i_stb,
  output logic [3:0] o_lvl,
  output logic [3:0] o_fall
);

  logic [3:0] r_smp;
  logic [3:0] r_prev;

  // Sample strobes and keep the previous sample; reset to the idle (high) level
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_smp  <= 4'hF;
      r_prev <= 4'hF;
    end else begin
      r_smp  <= i_stb;
      r_prev <= r_smp;
    end
  end

  assign o_lvl  = r_smp;
  assign o_fall = r_prev & ~r_smp;

endmodule

// File: rtl/jtcop_mcu_mbox.sv
// Main-CPU side mailbox to the i8751 protection MCU.
// The CPU writes a command word, the MCU is interrupted on INT1, reads the
// command through port 0 under port-2 read strobes and answers with two bytes
// under port-2 write strobes. A watchdog substitutes TOVAL if no answer comes.
// Ports:
//   clk, rstn  clock, asynchronous active-low reset
//   bus        jtcop_mcu_mbox_if.slave (CPU access + MCU ports)
// Parameters:
//   TIMEOUT    cycles allowed from command accept to response
//   TOVAL      response word used on timeout
module jtcop_mcu_mbox
  import jtcop_pkg::*;
#(
  parameter logic [19:0] TIMEOUT = 20'd240000,
  parameter logic [15:0] TOVAL   = 16'hFFFF
) (
  input  logic             clk,
  input  logic             rstn,
  jtcop_mcu_mbox_if.slave  bus
);

  state_t      r_state, w_state_nxt;
  logic [15:0] r_cmd, w_cmd;
  logic [15:0] r_rsp, w_rsp;
  logic [15:0] r_din, w_din;
  logic [7:0]  r_p0i, w_p0i;
  logic        r_intn, w_intn;
  logic [2:0]  r_st, w_st;
  logic        r_tmo, w_tmo;
  logic        r_ovr, w_ovr;
  logic [19:0] r_wd, w_wd;

  logic [3:0]  w_lvl;
  logic [3:0]  w_fall;
  logic        w_busy, w_rspv, w_expire;
  logic        w_wr_data, w_wr_stat, w_rd_data, w_rd_stat;
  logic [19:0] w_wd_inc;

  jtcop_mcu_edge u_edge (
    .clk    (clk),
    .rstn   (rstn),
    .i_stb  (bus.mcu_p2o[7:4]),
    .o_lvl  (w_lvl),
    .o_fall (w_fall)
  );

  assign w_busy    = (r_state == S_REQ) || (r_state == S_BUSY);
  assign w_rspv    = (r_state == S_RDY);
  assign w_wr_data = bus.cpu_cs & ~bus.cpu_addr & ~bus.cpu_rnw;
  assign w_wr_stat = bus.cpu_cs &  bus.cpu_addr & ~bus.cpu_rnw;
  assign w_rd_data = bus.cpu_cs & ~bus.cpu_addr &  bus.cpu_rnw;
  assign w_rd_stat = bus.cpu_cs &  bus.cpu_addr &  bus.cpu_rnw;
  assign w_wd_inc  = (r_wd == 20'hFFFFF) ? r_wd : r_wd + 20'd1;
  // r_wd counts completed REQ/BUSY cycles, so the TIMEOUT-th cycle ends the wait.
  assign w_expire  = w_busy && (r_wd >= TIMEOUT - 20'd1);

  // Next-state and next-register values for the whole mailbox
  always_comb begin
    w_state_nxt = r_state;
    w_cmd       = r_cmd;
    w_rsp       = r_rsp;
    w_din       = r_din;
    w_p0i       = r_p0i;
    w_intn      = r_intn;
    w_tmo       = r_tmo;
    w_ovr       = r_ovr;
    w_wd        = r_wd;
    w_st        = {w_busy, w_rspv, r_ovr};

    if (w_wr_stat) begin
      w_ovr = 1'b0;
    end else if (w_wr_data && (r_state != S_IDLE)) begin
      w_ovr = 1'b1;
    end else begin
      w_ovr = r_ovr;
    end

    if (w_rd_data) begin
      w_din = r_rsp;
    end else if (w_rd_stat) begin
      w_din = status_word(r_tmo, r_ovr, w_rspv, w_busy);
    end else begin
      w_din = r_din;
    end

    // High byte has priority when the MCU pulls both read strobes.
    if (w_busy && !w_lvl[STB_RDHI]) begin
      w_p0i = r_cmd[15:8];
    end else if (w_busy && !w_lvl[STB_RDLO]) begin
      w_p0i = r_cmd[7:0];
    end else begin
      w_p0i = r_p0i;
    end

    if (w_busy && w_fall[STB_WRHI]) begin
      w_rsp[15:8] = bus.mcu_p0o;
    end else begin
      w_rsp[15:8] = r_rsp[15:8];
    end

    case (r_state)
      S_IDLE: begin
        if (w_wr_data) begin
          w_cmd       = merge_be(r_cmd, bus.cpu_dout, bus.cpu_dsn);
          w_tmo       = 1'b0;
          w_wd        = 20'd0;
          w_intn      = 1'b0;
          w_state_nxt = S_REQ;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_REQ, S_BUSY: begin
        w_wd = w_wd_inc;
        // A low-byte write landing on the expiry cycle beats the watchdog.
        if (w_fall[STB_WRLO]) begin
          w_rsp[7:0]  = bus.mcu_p0o;
          w_intn      = 1'b1;
          w_state_nxt = S_RDY;
        end else if (w_expire) begin
          w_rsp       = TOVAL;
          w_tmo       = 1'b1;
          w_intn      = 1'b1;
          w_state_nxt = S_RDY;
        end else if ((r_state == S_REQ) && !bus.mcu_p2o[P2_ACK]) begin
          w_intn      = 1'b1;
          w_state_nxt = S_BUSY;
        end else begin
          w_state_nxt = r_state;
        end
      end
      S_RDY: begin
        if (w_rd_data) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_RDY;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_cmd   <= 16'd0;
      r_rsp   <= 16'd0;
      r_din   <= 16'd0;
      r_p0i   <= 8'h00;
      r_intn  <= 1'b1;
      r_st    <= 3'd0;
      r_tmo   <= 1'b0;
      r_ovr   <= 1'b0;
      r_wd    <= 20'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cmd   <= w_cmd;
      r_rsp   <= w_rsp;
      r_din   <= w_din;
      r_p0i   <= w_p0i;
      r_intn  <= w_intn;
      r_st    <= w_st;
      r_tmo   <= w_tmo;
      r_ovr   <= w_ovr;
      r_wd    <= w_wd;
    end
  end

  assign bus.cpu_din  = r_din;
  assign bus.mcu_p0i  = r_p0i;
  assign bus.mcu_intn = r_intn;
  assign bus.mcu_st   = r_st;

endmodule

// File: tb/tb_jtcop_mcu_mbox.sv
// Self-checking bench for jtcop_mcu_mbox (TIMEOUT shortened to 100 cycles).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_jtcop_mcu_mbox;

  logic clk;
  logic rstn;
  int   n_tests = 0;
  int   n_fail  = 0;

  jtcop_mcu_mbox_if bus ();

  jtcop_mcu_mbox #(.TIMEOUT(20'd100), .TOVAL(16'hFFFF)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, limit 200000 ns");
    $fatal(1, "bench time limit exceeded");
  end

  typedef struct {
    logic [1:0]  dsn;
    logic [15:0] dout;
    logic [7:0]  exp_hi;
    logic [7:0]  exp_lo;
    logic        wr_hi;
    logic [7:0]  rsp_hi;
    logic [7:0]  rsp_lo;
    logic [15:0] exp_rsp;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cpu_wr(input logic addr, input logic [1:0] dsn, input logic [15:0] dout);
    bus.cpu_cs   = 1'b1;
    bus.cpu_addr = addr;
    bus.cpu_rnw  = 1'b0;
    bus.cpu_dsn  = dsn;
    bus.cpu_dout = dout;
    @(negedge clk);
    bus.cpu_cs   = 1'b0;
    bus.cpu_rnw  = 1'b1;
    bus.cpu_dsn  = 2'b11;
  endtask

  task automatic cpu_rd(input logic addr, output logic [15:0] d);
    bus.cpu_cs   = 1'b1;
    bus.cpu_addr = addr;
    bus.cpu_rnw  = 1'b1;
    bus.cpu_dsn  = 2'b00;
    @(negedge clk);
    bus.cpu_cs   = 1'b0;
    bus.cpu_dsn  = 2'b11;
    d = bus.cpu_din;
  endtask

  task automatic mcu_ack();
    bus.mcu_p2o[3] = 1'b0;
    @(negedge clk);
    bus.mcu_p2o[3] = 1'b1;
  endtask

  // sel[0] pulls rdhi_n, sel[1] pulls rdlo_n; p0i is read two cycles later.
  task automatic mcu_rd(input logic [1:0] sel, output logic [7:0] b);
    bus.mcu_p2o[4] = ~sel[0];
    bus.mcu_p2o[5] = ~sel[1];
    nclk(2);
    b = bus.mcu_p0i;
    bus.mcu_p2o[5:4] = 2'b11;
    nclk(1);
  endtask

  task automatic mcu_wr(input logic hi, input logic [7:0] b);
    bus.mcu_p0o = b;
    if (hi) bus.mcu_p2o[7] = 1'b0;
    else    bus.mcu_p2o[6] = 1'b0;
    nclk(2);
    bus.mcu_p2o[7:6] = 2'b11;
    nclk(1);
  endtask

  initial begin
    logic [15:0] d;
    logic [7:0]  b;
    logic [15:0] dout;
    logic [1:0]  dsn;
    logic [1:0]  sel;
    logic [7:0]  rb;
    int mdl_cmd, mdl_rsp, mdl_ovr, hi, lo;

    tbl[0] = '{2'b00, 16'h1234, 8'h12, 8'h34, 1'b1, 8'hAB, 8'hCD, 16'hABCD};
    tbl[1] = '{2'b10, 16'hEE56, 8'h12, 8'h56, 1'b0, 8'h00, 8'h77, 16'hAB77};
    tbl[2] = '{2'b01, 16'h9AEE, 8'h9A, 8'h56, 1'b1, 8'h11, 8'h22, 16'h1122};
    tbl[3] = '{2'b11, 16'hFFFF, 8'h9A, 8'h56, 1'b0, 8'h00, 8'h00, 16'h1100};
    tbl[4] = '{2'b00, 16'h00FF, 8'h00, 8'hFF, 1'b1, 8'hFE, 8'h01, 16'hFE01};

    bus.cpu_cs = 1'b0; bus.cpu_addr = 1'b0; bus.cpu_rnw = 1'b1;
    bus.cpu_dsn = 2'b11; bus.cpu_dout = 16'h0000;
    bus.mcu_p0o = 8'h00; bus.mcu_p2o = 8'hFF;
    rstn = 1'b0;
    nclk(3);
    rstn = 1'b1;
    nclk(1);

    chk("rst_din",  bus.cpu_din, 16'h0000);
    chk("rst_p0i",  16'(bus.mcu_p0i), 16'h0000);
    chk("rst_intn", 16'(bus.mcu_intn), 16'h0001);
    chk("rst_st",   16'(bus.mcu_st), 16'h0000);

    // Table-driven full transactions
    for (int i = 0; i < 5; i++) begin
      cpu_wr(1'b0, tbl[i].dsn, tbl[i].dout);
      chk("tbl_intn_lo", 16'(bus.mcu_intn), 16'h0000);
      mcu_ack();
      chk("tbl_intn_hi", 16'(bus.mcu_intn), 16'h0001);
      chk("tbl_st_busy", 16'(bus.mcu_st), 16'h0004);
      cpu_rd(1'b1, d);
      chk("tbl_stat_busy", d, 16'h0001);
      mcu_rd(2'b01, b); chk("tbl_p0i_hi", 16'(b), 16'(tbl[i].exp_hi));
      mcu_rd(2'b10, b); chk("tbl_p0i_lo", 16'(b), 16'(tbl[i].exp_lo));
      mcu_rd(2'b11, b); chk("tbl_p0i_both", 16'(b), 16'(tbl[i].exp_hi));
      if (tbl[i].wr_hi) mcu_wr(1'b1, tbl[i].rsp_hi);
      mcu_wr(1'b0, tbl[i].rsp_lo);
      chk("tbl_st_rdy", 16'(bus.mcu_st), 16'h0002);
      cpu_rd(1'b1, d); chk("tbl_stat_rdy", d, 16'h0002);
      cpu_rd(1'b0, d); chk("tbl_rsp", d, tbl[i].exp_rsp);
      cpu_rd(1'b1, d); chk("tbl_stat_idle", d, 16'h0000);
    end

    // Overrun while busy, data read outside RDY, status-write clear
    cpu_wr(1'b0, 2'b00, 16'h4321);
    mcu_ack();
    cpu_wr(1'b0, 2'b00, 16'h9999);
    nclk(1);
    chk("ovr_st", 16'(bus.mcu_st), 16'h0005);
    cpu_rd(1'b1, d); chk("ovr_stat", d, 16'h0005);
    cpu_rd(1'b0, d); chk("early_data_rd", d, 16'hFE01);
    cpu_rd(1'b1, d); chk("early_rd_no_side_effect", d, 16'h0005);
    cpu_wr(1'b1, 2'b11, 16'h0000);
    cpu_rd(1'b1, d); chk("ovr_cleared", d, 16'h0001);
    mcu_rd(2'b01, b); chk("ovr_cmd_hi", 16'(b), 16'h0043);
    mcu_rd(2'b10, b); chk("ovr_cmd_lo", 16'(b), 16'h0021);
    mcu_wr(1'b0, 8'h10);
    cpu_rd(1'b1, d); chk("ovr_stat_rdy", d, 16'h0002);
    cpu_rd(1'b0, d); chk("ovr_rsp_keep_hi", d, 16'hFE10);

    // Randomized transactions against a word-level model
    mdl_cmd = 16'h4321;
    mdl_rsp = 16'hFE10;
    mdl_ovr = 0;
    for (int it = 0; it < 40; it++) begin
      dout = 16'($urandom);
      dsn  = 2'($urandom_range(0, 3));
      hi = dsn[1] ? mdl_cmd / 256 : int'(dout) / 256;
      lo = dsn[0] ? mdl_cmd % 256 : int'(dout) % 256;
      mdl_cmd = hi * 256 + lo;
      cpu_wr(1'b0, dsn, dout);
      chk("rnd_intn_lo", 16'(bus.mcu_intn), 16'h0000);
      nclk($urandom_range(0, 3));
      mcu_ack();
      chk("rnd_intn_hi", 16'(bus.mcu_intn), 16'h0001);
      if ($urandom_range(0, 1) == 1) begin
        cpu_wr(1'b0, 2'b00, 16'($urandom));
        mdl_ovr = 1;
      end
      if ($urandom_range(0, 2) == 0) begin
        cpu_wr(1'b1, 2'($urandom_range(0, 3)), 16'($urandom));
        mdl_ovr = 0;
      end
      cpu_rd(1'b1, d); chk("rnd_stat_busy", d, 16'(mdl_ovr * 4 + 1));
      sel = 2'($urandom_range(1, 3));
      mcu_rd(sel, b);
      chk("rnd_p0i", 16'(b), 16'((sel == 2'b10) ? lo : hi));
      if ($urandom_range(0, 1) == 1) begin
        rb = 8'($urandom);
        mcu_wr(1'b1, rb);
        mdl_rsp = int'(rb) * 256 + mdl_rsp % 256;
      end
      rb = 8'($urandom);
      mcu_wr(1'b0, rb);
      mdl_rsp = (mdl_rsp / 256) * 256 + int'(rb);
      chk("rnd_st_rdy", 16'(bus.mcu_st), 16'(2 + mdl_ovr));
      cpu_rd(1'b0, d); chk("rnd_rsp", d, 16'(mdl_rsp));
      cpu_rd(1'b1, d); chk("rnd_stat_idle", d, 16'(mdl_ovr * 4));
    end
    cpu_wr(1'b1, 2'b11, 16'h0000);

    // Watchdog expiry with no ack: intn low for exactly 100 cycles
    cpu_wr(1'b0, 2'b00, 16'h0F0F);
    chk("to_intn_lo_start", 16'(bus.mcu_intn), 16'h0000);
    nclk(99);
    chk("to_intn_lo_last", 16'(bus.mcu_intn), 16'h0000);
    nclk(1);
    chk("to_intn_hi", 16'(bus.mcu_intn), 16'h0001);
    cpu_rd(1'b1, d); chk("to_stat", d, 16'h000A);
    cpu_rd(1'b0, d); chk("to_rsp", d, 16'hFFFF);
    cpu_rd(1'b1, d); chk("to_stat_idle", d, 16'h0008);

    // wrlo edge landing on the expiry cycle: MCU data wins
    cpu_wr(1'b0, 2'b00, 16'h2468);
    mcu_ack();
    nclk(97);
    bus.mcu_p0o = 8'h5A;
    bus.mcu_p2o[6] = 1'b0;
    nclk(2);
    bus.mcu_p2o[6] = 1'b1;
    cpu_rd(1'b1, d); chk("race_stat", d, 16'h0002);
    cpu_rd(1'b0, d); chk("race_rsp", d, 16'hFF5A);

    // Reset during BUSY
    cpu_wr(1'b0, 2'b00, 16'h5555);
    mcu_ack();
    mcu_rd(2'b01, b); chk("pre_rst_p0i", 16'(b), 16'h0055);
    rstn = 1'b0;
    #1;
    chk("busy_rst_intn", 16'(bus.mcu_intn), 16'h0001);
    chk("busy_rst_st",   16'(bus.mcu_st), 16'h0000);
    chk("busy_rst_din",  bus.cpu_din, 16'h0000);
    chk("busy_rst_p0i",  16'(bus.mcu_p0i), 16'h0000);
    nclk(1);
    rstn = 1'b1;
    nclk(1);
    cpu_rd(1'b1, d); chk("post_rst_stat", d, 16'h0000);
    cpu_rd(1'b0, d); chk("post_rst_rsp", d, 16'h0000);
    cpu_wr(1'b0, 2'b00, 16'h0001);
    chk("post_rst_accept", 16'(bus.mcu_intn), 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jtcop_mcu_mbox.md
# jtcop_mcu_mbox

Main-CPU-side mailbox between the 68000 bus and the i8751 protection MCU on the Dec0/Robocop board. The CPU writes a 16-bit command word; the block raises the MCU INT1 request and serves the command bytes on MCU port 0 under port-2 read strobes. It then captures the MCU's response bytes under port-2 write strobes and presents the response word back to the CPU. A watchdog answers with a fixed value if the MCU never responds.

## Interface
- `TIMEOUT`, 20'd240000: cycles allowed from command write to response completion (10 ms at 24 MHz).
- `TOVAL`, 16'hFFFF: response word substituted on timeout.

- `clk`  in  1  system clock (MCU clock domain; CPU signals arrive synchronised)
- `rstn`  in  1  reset, asynchronous, active-low
- `cpu_cs`  in  1  one-cycle access strobe for the mailbox window
- `cpu_addr`  in  1  0 = data register, 1 = status register
- `cpu_rnw`  in  1  1 = read
- `cpu_dsn`  in  2  active-low byte enables {UDS, LDS}
- `cpu_dout`  in  16  write data from CPU
- `cpu_din`  out  16  registered read data to CPU
- `mcu_p0o`  in  8  MCU port 0 output (response byte)
- `mcu_p2o`  in  8  MCU port 2 output: [3] INT acknowledge (low clears), [4] rdhi_n, [5] rdlo_n, [6] wrlo_n, [7] wrhi_n
- `mcu_p0i`  out  8  byte driven to MCU port 0
- `mcu_intn`  out  1  INT1 request to MCU, active-low
- `mcu_st`  out  3  to MCU P3[7:5]: {busy, rsp_valid, overrun}

## Operation
- States: IDLE, REQ (intn low, waiting for ack), BUSY (MCU processing), RDY (response valid).
- IDLE: CPU write to data register loads `cmd` per byte enable (disabled bytes keep old value), clears `timeout` flag, starts watchdog, goes REQ.
- REQ: `mcu_p2o[3]` low -> intn high, go BUSY. Watchdog keeps running.
- BUSY/REQ: rdhi_n low -> `mcu_p0i` = cmd[15:8]; rdlo_n low -> cmd[7:0]; both low -> cmd[15:8]. Falling edge of wrhi_n latches p0o into rsp[15:8]; falling edge of wrlo_n latches rsp[7:0] and goes RDY. wrlo alone completes the transaction; hi byte keeps prior value if never written.
- Watchdog reaching TIMEOUT in REQ/BUSY: rsp = TOVAL, set `timeout` flag, intn high, go RDY. wrlo falling edge and expiry in the same cycle: MCU data wins, `timeout` stays 0.
- RDY: CPU read of data register returns rsp and goes IDLE. Status read returns {12'd0, timeout, overrun, rsp_valid, busy}; status reads have no side effect.
- CPU data write outside IDLE: ignored, `overrun` set; cleared by next CPU write to status register (any value).
- Data read outside RDY: returns last rsp, no state change.
- busy = state in {REQ, BUSY}; rsp_valid = state RDY.
- Reset: state IDLE; cmd, rsp, cpu_din = 0; mcu_p0i = 8'h00; mcu_intn = 1; mcu_st = 0; flags 0; watchdog 0.

## Timing
- mcu_intn falls the cycle after the accepting `cpu_cs` cycle; rises the cycle after ack is sampled low.
- Port-2 strobes sampled through one register; an edge is detected against the previous sample. `mcu_p0i` is valid 1 cycle after a read strobe is sampled low and holds until the next strobe.
- Response latch occurs 1 cycle after the edge is detected; rsp_valid is visible on `mcu_st` and status 1 cycle later.
- cpu_din is valid the cycle after `cpu_cs`; the state update on data read happens in that same cycle.
- Watchdog is 20 bits, saturating; TIMEOUT counts from the first REQ cycle.

## Structure
- Shared package `jtcop_pkg`: state encoding, P2 bit indices, status bit positions.
- One sub-module, `jtcop_mcu_edge`: 4-bit sample register plus falling-edge detector for p2o[7:4].

## Test plan
- Write 16'h1234, MCU acks, reads hi/lo -> p0i 8'h12 then 8'h34; MCU writes 8'hAB/8'hCD -> status 16'h0002, data read 16'hABCD, then status 16'h0000.
- LDS-only write of 16'hxx56 after 16'h1234 -> cmd 16'h1256.
- Second data write while BUSY -> ignored, status bit2 = 1; status write clears it.
- No ack with TIMEOUT=100 -> after 100 cycles intn high, data read 16'hFFFF, status bit3 = 1.
- wrlo edge on the expiry cycle -> response from MCU, timeout = 0.
- rstn low during BUSY -> intn 1, state IDLE, all outputs zero next cycle.
